hd_classify_engine: RTL and testbench

Parametrised hyperdimensional-computing inference engine: streams an encoded query hypervector in LANES-element chunks, computes the dot-product similarity against NUM_CLASSES class hypervectors held in an external class memory, and reports the best-matching class. It replaces the fixed 16-lane, 26-class similarity path behind the encoding MAC. Class count, hypervector length, lane count and widths are parameters. A start/done handshake and query backpressure are provided.

---
 rtl/hd_classify_engine.sv | 238 +++++++++++++++++++++++
 tb/tb_hd_classify_engine.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hd_classify_engine.sv
// ---------------------------------------------------------------------------
// hd_classify_engine
//
// Hyperdimensional-computing inference engine.  An encoded query hypervector
// arrives as CHUNKS chunks of LANES signed elements.  For every chunk, the
// engine reads the matching chunk of each class hypervector from an external
// class memory and accumulates the dot product into one accumulator per
// class.  After the last chunk, an argmax pass reports the best class.
//
// Optional feature (compile-time macro HD_ACC_SAT_EN):
//   defined   : every accumulation saturates to the signed ACC_WIDTH range
//   undefined : accumulation wraps modulo 2^ACC_WIDTH (two's complement)
//
// Ports
//   i_clk          clock, all state on the rising edge
//   i_rst_n        asynchronous active-low reset, clears all state
//   i_start        begin an inference (sampled only in IDLE)
//   i_q_valid      query chunk valid
//   i_q_data       query chunk, lane i at [i*ELEM_WIDTH +: ELEM_WIDTH]
//   o_q_ready      chunk accepted on the edge where i_q_valid & o_q_ready
//   o_class_rd_en  class memory read strobe
//   o_class_addr   class memory address = class*CHUNKS + chunk
//   i_class_data   class chunk, valid exactly one cycle after o_class_rd_en
//   o_busy         high whenever the engine is not IDLE
//   o_done         one-cycle pulse, result outputs valid
//   o_max_val      winning similarity, held until the next done
//   o_max_index    winning class, held until the next done
//   o_dbg_state    current FSM state
//
// Handshake: the query chunk transfers on the rising edge where i_q_valid
// and o_q_ready are both high; o_q_ready is high only in WAIT_Q and never
// depends on i_q_valid.
// ---------------------------------------------------------------------------
module hd_classify_engine #(
    parameter int NUM_CLASSES = 26,
    parameter int CHUNKS      = 250,
    parameter int LANES       = 16,
    parameter int ELEM_WIDTH  = 8,
    parameter int ACC_WIDTH   = 32,
    localparam int AW = $clog2(NUM_CLASSES * CHUNKS),
    localparam int IW = $clog2(NUM_CLASSES)
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_start,
    input  logic                        i_q_valid,
    input  logic [LANES*ELEM_WIDTH-1:0] i_q_data,
    output logic                        o_q_ready,
    output logic                        o_class_rd_en,
    output logic [AW-1:0]               o_class_addr,
    input  logic [LANES*ELEM_WIDTH-1:0] i_class_data,
    output logic                        o_busy,
    output logic                        o_done,
    output logic [ACC_WIDTH-1:0]        o_max_val,
    output logic [IW-1:0]               o_max_index,
    output logic [2:0]                  o_dbg_state
);

    localparam int CW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int KW = $clog2(NUM_CLASSES + 1);
    localparam int SW = 2 * ELEM_WIDTH + $clog2(LANES);
    // Wide enough to hold acc + lane_sum without loss, so saturation can
    // be decided by a plain signed compare.
    localparam int XW = ((ACC_WIDTH > SW) ? ACC_WIDTH : SW) + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT_Q = 3'd1,
        S_MAC    = 3'd2,
        S_ARGMAX = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                          r_state;
    state_t                          w_next;
    logic [CW-1:0]                   r_c;
    logic [KW-1:0]                   r_i;
    logic [LANES*ELEM_WIDTH-1:0]     r_q;
    logic signed [ACC_WIDTH-1:0]     r_acc [NUM_CLASSES];
    logic signed [ACC_WIDTH-1:0]     r_run_max;
    logic [IW-1:0]                   r_run_idx;
    logic [ACC_WIDTH-1:0]            r_max_val;
    logic [IW-1:0]                   r_max_index;

    logic                            w_mac_last;
    logic                            w_chunk_last;
    logic                            w_arg_last;
    logic                            w_rd;
    logic signed [2*ELEM_WIDTH-1:0]  w_prod;
    logic signed [SW-1:0]            w_lane_sum;
    logic signed [ACC_WIDTH-1:0]     w_acc_mac;
    logic signed [ACC_WIDTH-1:0]     w_acc_arg;
    logic signed [XW-1:0]            w_sum_x;
    logic signed [ACC_WIDTH-1:0]     w_acc_new;
    logic                            w_better;
    logic signed [ACC_WIDTH-1:0]     w_best_val;
    logic [IW-1:0]                   w_best_idx;

`ifdef HD_ACC_SAT_EN
    localparam logic signed [XW-1:0] SAT_HI =
        {{(XW-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [XW-1:0] SAT_LO =
        {{(XW-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};
`endif

    assign w_mac_last   = (r_i == KW'(NUM_CLASSES));
    assign w_chunk_last = (r_c == CW'(CHUNKS - 1));
    assign w_arg_last   = (r_i == KW'(NUM_CLASSES - 1));

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (i_start)   w_next = S_WAIT_Q;
            S_WAIT_Q: if (i_q_valid) w_next = S_MAC;
            S_MAC:    if (w_mac_last) w_next = w_chunk_last ? S_ARGMAX : S_WAIT_Q;
            S_ARGMAX: if (w_arg_last) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Reads are issued for MAC index 0..NUM_CLASSES-1; the extra last MAC
    // cycle only consumes the data returned for the final class.
    always_comb begin
        w_rd          = (r_state == S_MAC) && (r_i < KW'(NUM_CLASSES));
        o_q_ready     = (r_state == S_WAIT_Q);
        o_class_rd_en = w_rd;
        o_class_addr  = '0;
        if (w_rd) begin
            o_class_addr = AW'(r_i) * AW'(CHUNKS) + AW'(r_c);
        end
        o_busy        = (r_state != S_IDLE);
        o_done        = (r_state == S_DONE);
        o_max_val     = r_max_val;
        o_max_index   = r_max_index;
        o_dbg_state   = r_state;
    end

    // Dot product of the latched query chunk with the returned class chunk.
    always_comb begin
        w_lane_sum = '0;
        w_prod     = '0;
        for (int l = 0; l < LANES; l++) begin
            w_prod     = $signed(r_q[l*ELEM_WIDTH +: ELEM_WIDTH]) *
                         $signed(i_class_data[l*ELEM_WIDTH +: ELEM_WIDTH]);
            w_lane_sum = w_lane_sum + SW'(w_prod);
        end
    end

    // Data arriving in MAC cycle i belongs to class i-1; argmax walks class i.
    always_comb begin
        w_acc_mac = '0;
        w_acc_arg = '0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            if (r_i == KW'(k + 1)) w_acc_mac = r_acc[k];
            if (r_i == KW'(k))     w_acc_arg = r_acc[k];
        end
    end

    always_comb begin
        w_sum_x   = XW'(w_acc_mac) + XW'(w_lane_sum);
        w_acc_new = ACC_WIDTH'(w_sum_x);
`ifdef HD_ACC_SAT_EN
        if (w_sum_x > SAT_HI) begin
            w_acc_new = ACC_WIDTH'(SAT_HI);
        end else if (w_sum_x < SAT_LO) begin
            w_acc_new = ACC_WIDTH'(SAT_LO);
        end
`endif
    end

    // Strictly-greater replacement keeps ties on the lowest index.
    always_comb begin
        w_better   = (r_i == '0) || (w_acc_arg > r_run_max);
        w_best_val = w_better ? w_acc_arg : r_run_max;
        w_best_idx = w_better ? IW'(r_i) : r_run_idx;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_c         <= '0;
            r_i         <= '0;
            r_q         <= '0;
            r_run_max   <= '0;
            r_run_idx   <= '0;
            r_max_val   <= '0;
            r_max_index <= '0;
            for (int k = 0; k < NUM_CLASSES; k++) begin
                r_acc[k] <= '0;
            end
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_c <= '0;
                        r_i <= '0;
                        for (int k = 0; k < NUM_CLASSES; k++) begin
                            r_acc[k] <= '0;
                        end
                    end
                end
                S_WAIT_Q: begin
                    if (i_q_valid) begin
                        r_q <= i_q_data;
                        r_i <= '0;
                    end
                end
                S_MAC: begin
                    for (int k = 0; k < NUM_CLASSES; k++) begin
                        if (r_i == KW'(k + 1)) r_acc[k] <= w_acc_new;
                    end
                    if (w_mac_last) begin
                        r_i <= '0;
                        r_c <= w_chunk_last ? '0 : r_c + CW'(1);
                    end else begin
                        r_i <= r_i + KW'(1);
                    end
                end
                S_ARGMAX: begin
                    r_run_max <= w_best_val;
                    r_run_idx <= w_best_idx;
                    r_i       <= r_i + KW'(1);
                    if (w_arg_last) begin
                        r_i         <= '0;
                        r_max_val   <= w_best_val;
                        r_max_index <= w_best_idx;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hd_classify_engine.sv
// ---------------------------------------------------------------------------
// Testbench for hd_classify_engine (NUM_CLASSES=4, CHUNKS=2, LANES=4,
// ELEM_WIDTH=8, ACC_WIDTH=16).  A reference model computes the similarity of
// every class with integer arithmetic (then wraps or saturates to 16 bits
// depending on HD_ACC_SAT_EN) and picks the first maximum; the result is
// queued when a run is issued and popped by a monitor on every done pulse.
// ---------------------------------------------------------------------------
module tb_hd_classify_engine;

    localparam int N   = 4;
    localparam int C   = 2;
    localparam int L   = 4;
    localparam int EW  = 8;
    localparam int ACC = 16;
    localparam int ADW = $clog2(N * C);
    localparam int IDW = $clog2(N);
    localparam int RW  = ACC + IDW;

    // clock / reset
    logic clk = 1'b0;
    logic i_rst_n;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic              i_start;
    logic              i_q_valid;
    logic [L*EW-1:0]   i_q_data;
    logic              o_q_ready;
    logic              o_class_rd_en;
    logic [ADW-1:0]    o_class_addr;
    logic [L*EW-1:0]   i_class_data;
    logic              o_busy;
    logic              o_done;
    logic [ACC-1:0]    o_max_val;
    logic [IDW-1:0]    o_max_index;
    logic [2:0]        o_dbg_state;

    hd_classify_engine #(
        .NUM_CLASSES(N), .CHUNKS(C), .LANES(L), .ELEM_WIDTH(EW), .ACC_WIDTH(ACC)
    ) u_dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_start(i_start),
        .i_q_valid(i_q_valid), .i_q_data(i_q_data), .o_q_ready(o_q_ready),
        .o_class_rd_en(o_class_rd_en), .o_class_addr(o_class_addr),
        .i_class_data(i_class_data), .o_busy(o_busy), .o_done(o_done),
        .o_max_val(o_max_val), .o_max_index(o_max_index), .o_dbg_state(o_dbg_state)
    );

    // stimulus memories: query chunks and class memory contents
    logic signed [EW-1:0] qv [C][L];
    logic signed [EW-1:0] cm [N*C][L];
    int tv [4][2] = '{'{1, 1}, '{2, 3}, '{3, 2}, '{1, 0}};

    // class memory: one-cycle read latency
    always @(posedge clk) begin
        if (o_class_rd_en) begin
            for (int l = 0; l < L; l++) i_class_data[l*EW +: EW] <= cm[o_class_addr][l];
        end
    end

    // scoreboard
    logic [RW-1:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // reference model
    function automatic int accum(input int a, input int s);
        int t;
        t = a + s;
`ifdef HD_ACC_SAT_EN
        if (t > (1 << (ACC - 1)) - 1) t = (1 << (ACC - 1)) - 1;
        if (t < -(1 << (ACC - 1)))    t = -(1 << (ACC - 1));
`else
        t = t & ((1 << ACC) - 1);
        if (t >= (1 << (ACC - 1))) t = t - (1 << ACC);
`endif
        return t;
    endfunction

    function automatic logic [RW-1:0] model_result();
        int acc [N];
        int s;
        int best;
        for (int k = 0; k < N; k++) begin
            acc[k] = 0;
            for (int c = 0; c < C; c++) begin
                s = 0;
                for (int l = 0; l < L; l++) s += int'(qv[c][l]) * int'(cm[k*C+c][l]);
                acc[k] = accum(acc[k], s);
            end
        end
        best = 0;
        for (int k = 1; k < N; k++) if (acc[k] > acc[best]) best = k;
        return {ACC'(acc[best]), IDW'(best)};
    endfunction

    function automatic logic [L*EW-1:0] pack_q(input int c);
        logic [L*EW-1:0] r;
        for (int l = 0; l < L; l++) r[l*EW +: EW] = qv[c][l];
        return r;
    endfunction

    // scenario fill: 0 ramp, 1 tie, 2 negative, 3 overflow, 4 random
    task automatic fill(input int kind);
        for (int c = 0; c < C; c++) begin
            for (int l = 0; l < L; l++) begin
                case (kind)
                    3:       qv[c][l] = 8'sd127;
                    4:       qv[c][l] = EW'($urandom_range(0, 255));
                    default: qv[c][l] = 8'sd1;
                endcase
                for (int k = 0; k < N; k++) begin
                    case (kind)
                        0:       cm[k*C+c][l] = EW'(k + 1);
                        1:       cm[k*C+c][l] = EW'(tv[k][c]);
                        2:       cm[k*C+c][l] = EW'(-(k + 1));
                        3:       cm[k*C+c][l] = 8'sd127;
                        default: cm[k*C+c][l] = EW'($urandom_range(0, 255));
                    endcase
                end
            end
        end
    endtask

    // monitor: every done pulse is matched against the expected queue
    always @(negedge clk) begin
        if (o_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                timeout("unexpected_done");
            end else begin
                check("result", {o_max_val, o_max_index}, exp_q.pop_front());
            end
        end
    end

    // driver: one full inference
    task automatic run(input int gap, input bit inject_start, input bit abort_mid, input bit chk_lat);
        int s;
        int d;
        int guard;
        bit aborted;
        aborted = 1'b0;
        if (!abort_mid) exp_q.push_back(model_result());
        @(negedge clk);
        i_start = 1'b1;
        s = cyc;
        @(negedge clk);
        i_start = 1'b0;
        check("busy_after_start", o_busy, 1);
        check("ready_after_start", o_q_ready, 1);
        for (int c = 0; c < C; c++) begin
            if (gap > 0 && c > 0) repeat (gap) @(negedge clk);
            i_q_valid = 1'b1;
            i_q_data  = pack_q(c);
            guard = 0;
            while (!o_q_ready && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            if (!o_q_ready) timeout("q_ready_wait");
            @(negedge clk);
            if (gap > 0 || c == C - 1) i_q_valid = 1'b0;
            for (int i = 0; i < N; i++) begin
                check("rd_en", o_class_rd_en, 1);
                check("class_addr", o_class_addr, i * C + c);
                if (inject_start && i == 1) i_start = 1'b1;
                if (i == 2) i_start = 1'b0;
                if (abort_mid && i == 1) begin
                    i_rst_n = 1'b0;
                    #1;
                    check("rst_busy", o_busy, 0);
                    check("rst_done", o_done, 0);
                    check("rst_ready", o_q_ready, 0);
                    check("rst_rd_en", o_class_rd_en, 0);
                    check("rst_addr", o_class_addr, 0);
                    check("rst_max", {o_max_val, o_max_index}, 0);
                    @(negedge clk);
                    i_rst_n   = 1'b1;
                    i_q_valid = 1'b0;
                    aborted   = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            if (aborted) break;
            check("rd_en_last_mac", o_class_rd_en, 0);
            @(negedge clk);
        end
        if (aborted) begin
            repeat (3) @(negedge clk);
            check("abort_idle_busy", o_busy, 0);
            return;
        end
        guard = 0;
        while (!o_done && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!o_done) timeout("done_wait");
        d = cyc;
        if (chk_lat) check("start_to_done", d - s + 1, 1 + C * (N + 2) + N + 1);
        @(negedge clk);
        check("done_pulse_len", o_done, 0);
        check("idle_busy", o_busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        i_rst_n   = 1'b0;
        i_start   = 1'b0;
        i_q_valid = 1'b0;
        i_q_data  = '0;
        repeat (3) @(negedge clk);
        check("reset_ready", o_q_ready, 0);
        check("reset_rd_en", o_class_rd_en, 0);
        check("reset_addr", o_class_addr, 0);
        check("reset_busy", o_busy, 0);
        check("reset_done", o_done, 0);
        check("reset_max_val", o_max_val, 0);
        check("reset_max_index", o_max_index, 0);
        i_rst_n = 1'b1;
        @(negedge clk);

        fill(0); run(0, 0, 0, 1);   // ramp: class 3 wins with 32
        fill(1); run(0, 0, 0, 1);   // tie 20/20: lowest index wins
        fill(2); run(0, 0, 0, 0);   // all negative: class 0 with -8
        fill(3); run(0, 0, 0, 0);   // overflow of the 16-bit accumulator
        fill(0); run(5, 0, 0, 0);   // gaps between chunks
        run(0, 1, 0, 1);            // start pulsed during MAC
        run(0, 0, 1, 0);            // reset mid-MAC, no result
        run(0, 0, 0, 1);            // fresh run after the reset
        for (int r = 0; r < 8; r++) begin
            fill(4);
            gap = $urandom_range(0, 3);
            run(gap, r[0], 0, gap == 0);
        end

        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
